alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Packet sequencer for the UART ALU. Parses the byte stream arriving from the UART receiver, collects 32-bit little-endian operands, sequences them one pair at a time through a shared arithmetic unit (add/mul/div), and streams the 4-byte result or the echoed payload back to the UART transmitter. It sits between `uart_rx`/`uart_tx` and the arithmetic datapath, and owns every handshake between them.

## Interface
- `TimeoutCycles`, default 120000 (10 ms at 12 MHz): inter-byte timeout, used only with `ALU_CTRL_TIMEOUT_EN`.
- `clk_i  in  1  system clock (12 MHz)`
- `rst_ni  in  1  reset; asynchronous, active-low`
- `rx_data_i  in  8  received byte`
- `rx_valid_i  in  1  received byte valid`
- `rx_ready_o  out  1  controller accepts byte`
- `tx_data_o  out  8  byte to transmit`
- `tx_valid_o  out  1  transmit byte valid`
- `tx_ready_i  in  1  transmitter accepts byte`
- `op_code_o  out  2  0=ADD, 1=MUL, 2=DIV (quotient)`
- `op_a_o, op_b_o  out  32  operands (a = accumulator, b = new operand)`
- `op_valid_o  out  1  operation request`
- `op_ready_i  in  1  arithmetic unit accepts request`
- `res_i  in  32  result`
- `res_valid_i  in  1  one-cycle result strobe`

## Operation
- Packet format: opcode, reserved, len_lo, len_hi, then (len-4) payload bytes. `len` is the 16-bit total packet length including the header.
- Opcodes: 0xEC echo, 0xA0 add, 0x88 mul, 0xD0 div. Any other opcode: drain len-4 bytes, send nothing.
- States: IDLE, HDR_RSV, LEN_LO, LEN_HI, ECHO, LOAD, ISSUE, WAIT_RES, SEND, DRAIN.
- IDLE to HDR_RSV on any accepted byte; that byte is latched as the opcode. HDR_RSV to LEN_LO to LEN_HI, one accepted byte each.
- After LEN_HI, compute remaining = len-4. If len < 4, treat remaining as 0.
  - Echo: go to ECHO; remaining 0 goes to IDLE.
  - Arithmetic: go to LOAD.
  - Unknown opcode: go to DRAIN.
- ECHO: combinational pass-through. `tx_data_o = rx_data_i`, `tx_valid_o = rx_valid_i`, `rx_ready_o = tx_ready_i`. Decrement remaining on each handshake; return to IDLE after the last byte.
- LOAD: assemble 4 bytes, LSB first.
  - First complete word goes to the accumulator (acc).
  - Each later word becomes `op_b`, then go to ISSUE.
- ISSUE: `op_valid_o = 1`. `op_a_o`, `op_b_o` and `op_code_o` are held stable until `op_ready_i`, then go to WAIT_RES.
- WAIT_RES: on `res_valid_i`, acc <= `res_i`. Then go to LOAD if words remain, else SEND.
- Trailing bytes when remaining is not a multiple of 4 are accepted and discarded; a partial word is never issued.
- Zero complete words: acc = 0. Exactly one word: result = that word, and no request is issued.
- SEND: emit acc as 4 bytes, LSB first; a byte advances only on `tx_valid_o && tx_ready_i`. Then go to IDLE.
- DRAIN: accept and discard remaining bytes, then go to IDLE.
- The controller does not check or resolve DIV by zero; the arithmetic unit's result is returned unchanged.

## Timing
- Reset values: state IDLE; acc 0; all data outputs 0; `rx_ready_o`, `tx_valid_o`, `op_valid_o` all 0.
- `rx_ready_o` is 1 in IDLE, HDR_RSV, LEN_LO, LEN_HI, LOAD and DRAIN. It is 0 in ISSUE, WAIT_RES and SEND, so the UART back-pressures the stream.
- Every byte is registered on the `rx_valid_i && rx_ready_o` edge. The state transition takes effect on the next cycle.
- First SEND byte appears the cycle after the final `res_valid_i`, or the cycle after the last payload byte if no operation was issued.
- `res_valid_i` arriving outside WAIT_RES is ignored.
- Reset asserted mid-packet: immediate return to IDLE, with all outputs at their reset values.

## Configuration
- `ALU_CTRL_TIMEOUT_EN` defined: a counter runs in HDR_RSV through LOAD and in DRAIN.
  - The counter clears on each accepted byte.
  - On reaching `TimeoutCycles` it forces IDLE and discards the partial packet.
  - ECHO, ISSUE, WAIT_RES and SEND never time out.
- Undefined: no counter; a truncated packet stalls until more bytes arrive or reset.

## Structure
- `alu_pkg` holds:
  - the opcode enum (ECHO/ADD/MUL/DIV byte values);
  - the `op_code_o` encoding;
  - the state enum;
  - the header length constant (4).
- One sub-module, `byte_word_pack`, shifts in 4 bytes LSB first and flags word-complete. It has a clear input used on header and reset.

## Test plan
- Echo: EC 00 07 00 41 42 43 -> tx 41 42 43, then IDLE; stall `tx_ready_i` for 10 cycles mid-stream and no byte is lost.
- Add: A0 00 10 00, then words 1, 2, 3 -> three 32-bit operands; two ADD requests with a = 1, b = 2, then a = 3, b = 3; tx 06 00 00 00.
- Mul with a slow arithmetic unit: 88 00 0C 00, 0x00000007, 0x00000006; `op_ready_i` delayed 5 cycles, result 20 cycles later -> operands stable while waiting; tx 2A 00 00 00.
- Unknown opcode 0x55 with len 8, then a valid add packet -> 4 bytes drained with no tx; the add packet completes correctly.
- Boundaries:
  - Add with len 9 (one word plus one trailing byte) -> no request issued, the word is echoed as the result.
  - Add with len 4 -> tx 00 00 00 00.
- Reset pulsed mid-LOAD -> outputs at reset values within one cycle and the next packet parses cleanly. With `ALU_CTRL_TIMEOUT_EN`, a packet stopping after 2 header bytes returns to IDLE after `TimeoutCycles`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the UART ALU packet sequencer: opcode bytes, arithmetic
// unit encoding, sequencer states and the fixed header length.
package alu_pkg;

   typedef enum logic [7:0] {
      OPC_MUL  = 8'h88,
      OPC_ADD  = 8'hA0,
      OPC_DIV  = 8'hD0,
      OPC_ECHO = 8'hEC
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_MUL = 2'd1,
      ALU_DIV = 2'd2
   } alu_op_e;

   typedef enum logic [3:0] {
      IDLE,
      HDR_RSV,
      LEN_LO,
      LEN_HI,
      ECHO,
      LOAD,
      ISSUE,
      WAIT_RES,
      SEND,
      DRAIN
   } state_e;

   localparam logic [15:0] HdrLen = 16'd4;

   function automatic logic is_arith(input logic [7:0] opc);
      return (opc == OPC_ADD) || (opc == OPC_MUL) || (opc == OPC_DIV);
   endfunction

   // Unknown opcodes never reach ISSUE, so their mapping is irrelevant.
   function automatic alu_op_e to_alu_op(input logic [7:0] opc);
      if (opc == OPC_MUL) return ALU_MUL;
      if (opc == OPC_DIV) return ALU_DIV;
      return ALU_ADD;
   endfunction

endpackage

// File: rtl/alu_ctrl_byte_word_pack.sv
// byte_word_pack: gathers four bytes LSB first into a 32-bit word and flags
// the cycle in which the fourth byte arrives (word_o is valid in that cycle).
module byte_word_pack (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o
);

   logic [23:0] low_bytes_q;
   logic [1:0]  count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         low_bytes_q <= '0;
         count_q     <= '0;
      end else if (clear_i) begin
         low_bytes_q <= '0;
         count_q     <= '0;
      end else if (shift_i) begin
         low_bytes_q <= {byte_i, low_bytes_q[23:8]};
         count_q     <= count_q + 2'd1;
      end
   end

   assign word_o      = {byte_i, low_bytes_q};
   assign word_done_o = shift_i && (count_q == 2'd3);

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: parses UART packets, sequences operand pairs through the shared
// arithmetic unit and returns the result or echo. Optional: ALU_CTRL_TIMEOUT_EN.
module alu_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 120000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic [1:0]  op_code_o,
   output logic [31:0] op_a_o,
   output logic [31:0] op_b_o,
   output logic        op_valid_o,
   input  logic        op_ready_i,
   input  logic [31:0] res_i,
   input  logic        res_valid_i
);

   state_e      state_q, state_d;
   logic [7:0]  opcode_q;
   logic [7:0]  len_lo_q;
   logic [15:0] remaining_q;
   logic [31:0] acc_q;
   logic [31:0] op_b_q;
   logic        have_acc_q;
   logic [1:0]  send_idx_q;

   logic        rx_hs;
   logic        tx_hs;
   logic [15:0] len_full;
   logic [15:0] rem_init;
   logic        last_byte;
   logic [31:0] packed_word;
   logic        word_done;
   logic        timeout_hit;

   assign rx_hs     = rx_valid_i && rx_ready_o;
   assign tx_hs     = tx_valid_o && tx_ready_i;
   assign len_full  = {rx_data_i, len_lo_q};
   assign rem_init  = (len_full < HdrLen) ? 16'd0 : (len_full - HdrLen);
   assign last_byte = (remaining_q == 16'd1);

   // rx_ready_o is constant 1 in LOAD, so rx_valid_i alone qualifies the
   // shift; this keeps the packer off the rx_ready_o combinational path.
   byte_word_pack u_pack (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (state_q == LEN_HI),
      .shift_i     ((state_q == LOAD) && rx_valid_i),
      .byte_i      (rx_data_i),
      .word_o      (packed_word),
      .word_done_o (word_done)
   );

`ifdef ALU_CTRL_TIMEOUT_EN
   logic [31:0] idle_cnt_q;
   logic        timed_state;

   assign timed_state = state_q inside {HDR_RSV, LEN_LO, LEN_HI, LOAD, DRAIN};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idle_cnt_q <= '0;
      end else if (!timed_state || rx_hs) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_q + 32'd1;
      end
   end

   assign timeout_hit = timed_state && !rx_hs && (idle_cnt_q >= 32'(TimeoutCycles - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TimeoutCycles;
   assign timeout_hit        = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rx_ready_o = 1'b0;
      tx_valid_o = 1'b0;
      tx_data_o  = 8'h00;
      op_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) state_d = HDR_RSV;
         end
         HDR_RSV: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) state_d = LEN_LO;
         end
         LEN_LO: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) state_d = LEN_HI;
         end
         LEN_HI: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) begin
               if (opcode_q == OPC_ECHO) begin
                  state_d = (rem_init == 16'd0) ? IDLE : ECHO;
               end else if (is_arith(opcode_q)) begin
                  state_d = (rem_init == 16'd0) ? SEND : LOAD;
               end else begin
                  state_d = (rem_init == 16'd0) ? IDLE : DRAIN;
               end
            end
         end
         ECHO: begin
            tx_data_o  = rx_data_i;
            tx_valid_o = rx_valid_i;
            rx_ready_o = tx_ready_i;
            if (rx_valid_i && tx_ready_i && last_byte) state_d = IDLE;
         end
         LOAD: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) begin
               if (word_done && have_acc_q) begin
                  state_d = ISSUE;
               end else if (last_byte) begin
                  state_d = SEND;
               end
            end
         end
         ISSUE: begin
            op_valid_o = 1'b1;
            if (op_ready_i) state_d = WAIT_RES;
         end
         WAIT_RES: begin
            if (res_valid_i) state_d = (remaining_q == 16'd0) ? SEND : LOAD;
         end
         SEND: begin
            tx_valid_o = 1'b1;
            tx_data_o  = acc_q[{send_idx_q, 3'b000} +: 8];
            if (tx_ready_i && (send_idx_q == 2'd3)) state_d = IDLE;
         end
         DRAIN: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i && last_byte) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (timeout_hit) state_d = IDLE;
      // Outputs must read as their reset values while reset is held.
      if (!rst_ni) begin
         rx_ready_o = 1'b0;
         tx_valid_o = 1'b0;
         tx_data_o  = 8'h00;
         op_valid_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         opcode_q    <= '0;
         len_lo_q    <= '0;
         remaining_q <= '0;
         acc_q       <= '0;
         op_b_q      <= '0;
         have_acc_q  <= 1'b0;
         send_idx_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rx_hs) opcode_q <= rx_data_i;
            end
            LEN_LO: begin
               if (rx_hs) len_lo_q <= rx_data_i;
            end
            LEN_HI: begin
               if (rx_hs) begin
                  remaining_q <= rem_init;
                  acc_q       <= '0;
                  have_acc_q  <= 1'b0;
                  send_idx_q  <= '0;
               end
            end
            ECHO, DRAIN: begin
               if (rx_hs) remaining_q <= remaining_q - 16'd1;
            end
            LOAD: begin
               if (rx_hs) begin
                  remaining_q <= remaining_q - 16'd1;
                  if (word_done) begin
                     if (have_acc_q) begin
                        op_b_q <= packed_word;
                     end else begin
                        acc_q      <= packed_word;
                        have_acc_q <= 1'b1;
                     end
                  end
               end
            end
            WAIT_RES: begin
               if (res_valid_i) acc_q <= res_i;
            end
            SEND: begin
               if (tx_hs) send_idx_q <= send_idx_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign op_code_o = to_alu_op(opcode_q);
   assign op_a_o    = acc_q;
   assign op_b_o    = op_b_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed packets plus randomized traffic
// compared against a packet-level reference model.
module tb_alu_ctrl;

   localparam int TimeoutLimit = 64;
   localparam int ByteBudget   = 400;

   logic        clock = 1'b0;
   logic        rstN;
   logic [7:0]  rxData;
   logic        rxValid;
   logic        rxReady;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady;
   logic [1:0]  opCode;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        opValid;
   logic        opReady;
   logic [31:0] resData;
   logic        resValid;

   int checksTotal  = 0;
   int checksPassed = 0;
   int cycleCount   = 0;
   int stallFrom    = 0;
   int stallTo      = 0;
   bit randomTx     = 0;
   bit randomGaps   = 0;
   int readyDelay   = 0;
   int resDelay     = 0;

   logic [7:0]  gotTx[$];
   logic [65:0] gotReq[$];
   bit          gotHeld[$];
   logic [7:0]  payload[$];
   logic [7:0]  pktBytes[$];
   logic [7:0]  expTx[$];
   logic [65:0] expReq[$];
   int          txBase;
   int          reqBase;

   alu_ctrl #(.TimeoutCycles(TimeoutLimit)) dut (
      .clk_i       (clock),
      .rst_ni      (rstN),
      .rx_data_i   (rxData),
      .rx_valid_i  (rxValid),
      .rx_ready_o  (rxReady),
      .tx_data_o   (txData),
      .tx_valid_o  (txValid),
      .tx_ready_i  (txReady),
      .op_code_o   (opCode),
      .op_a_o      (opA),
      .op_b_o      (opB),
      .op_valid_o  (opValid),
      .op_ready_i  (opReady),
      .res_i       (resData),
      .res_valid_i (resValid)
   );

   initial forever #5 clock = ~clock;

   always @(posedge clock) cycleCount <= cycleCount + 1;

   // Arithmetic unit behaviour shared by the unit model and the reference.
   function automatic logic [31:0] aluResult(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
      case (code)
         2'd0:    return a + b;
         2'd1:    return a * b;
         2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default: return 32'd0;
      endcase
   endfunction

   // Transmit sink: optional fixed stall window and random back-pressure.
   initial begin
      txReady = 1'b1;
      forever begin
         @(negedge clock);
         txReady = !(cycleCount >= stallFrom && cycleCount < stallTo) &&
                   (!randomTx || ($urandom_range(0, 3) != 0));
         #1;
         if (rstN && txValid && txReady) gotTx.push_back(txData);
      end
   end

   // Arithmetic unit model with programmable accept and result latency.
   initial begin
      logic [31:0] capA;
      logic [31:0] capB;
      logic [1:0]  capCode;
      bit          held;
      opReady  = 1'b0;
      resValid = 1'b0;
      resData  = 32'd0;
      forever begin
         @(negedge clock);
         resValid = 1'b0;
         if (rstN && opValid) begin
            capA    = opA;
            capB    = opB;
            capCode = opCode;
            held    = 1'b1;
            for (int i = 0; i < readyDelay; i++) begin
               @(negedge clock);
               if (opA !== capA || opB !== capB || opCode !== capCode || opValid !== 1'b1) held = 1'b0;
            end
            opReady = 1'b1;
            @(negedge clock);
            opReady = 1'b0;
            gotReq.push_back({capCode, capA, capB});
            gotHeld.push_back(held);
            for (int i = 0; i < resDelay; i++) @(negedge clock);
            resValid = 1'b1;
            resData  = aluResult(capCode, capA, capB);
         end
      end
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [65:0] observed, input logic [65:0] expected);
      checksTotal++;
      assert (observed === expected) checksPassed++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // Packet-level reference: echo returns the payload, arithmetic folds the
   // complete little-endian words left to right, anything else is silent.
   task automatic modelPacket(input logic [7:0] opc);
      logic [31:0] acc;
      logic [31:0] w;
      logic [1:0]  code;
      int          words;
      expTx  = {};
      expReq = {};
      if (opc == 8'hEC) begin
         foreach (payload[k]) expTx.push_back(payload[k]);
      end else if (opc == 8'hA0 || opc == 8'h88 || opc == 8'hD0) begin
         code  = (opc == 8'hA0) ? 2'd0 : (opc == 8'h88) ? 2'd1 : 2'd2;
         words = payload.size() / 4;
         acc   = 32'd0;
         for (int k = 0; k < words; k++) begin
            w = {payload[4*k+3], payload[4*k+2], payload[4*k+1], payload[4*k]};
            if (k == 0) begin
               acc = w;
            end else begin
               expReq.push_back({code, acc, w});
               acc = aluResult(code, acc, w);
            end
         end
         for (int k = 0; k < 4; k++) expTx.push_back(acc[8*k +: 8]);
      end
   endtask

   task automatic pushWord(input logic [31:0] w);
      for (int k = 0; k < 4; k++) payload.push_back(w[8*k +: 8]);
   endtask

   task automatic preparePacket(input logic [7:0] opc, input int len);
      pktBytes = {};
      pktBytes.push_back(opc);
      pktBytes.push_back(8'h00);
      pktBytes.push_back(8'(len));
      pktBytes.push_back(8'(len >> 8));
      foreach (payload[k]) pktBytes.push_back(payload[k]);
      modelPacket(opc);
      txBase  = gotTx.size();
      reqBase = gotReq.size();
   endtask

   // Called on a falling edge; returns on a falling edge.
   task automatic sendByte(input logic [7:0] value, output bit accepted);
      int waited = 0;
      rxData   = value;
      rxValid  = 1'b1;
      accepted = 1'b0;
      while (!accepted && waited < ByteBudget) begin
         #1;
         if (rxReady) accepted = 1'b1;
         @(negedge clock);
         waited++;
      end
      rxValid = 1'b0;
   endtask

   task automatic applyStimulus(input string tag, input int first, input int last);
      bit ok;
      int accepted = 0;
      for (int k = first; k < last; k++) begin
         if (randomGaps) repeat ($urandom_range(0, 2)) @(negedge clock);
         sendByte(pktBytes[k], ok);
         if (ok) accepted++;
      end
      checkOutput({tag, " bytesAccepted"}, 66'(accepted), 66'(last - first));
   endtask

   task automatic finishPacket(input string tag);
      int waited = 0;
      int gotCount;
      while (gotTx.size() < txBase + expTx.size() && waited < 2000) begin
         @(negedge clock);
         waited++;
      end
      repeat (6) @(negedge clock);
      #1;
      gotCount = gotTx.size() - txBase;
      checkOutput({tag, " txCount"}, 66'(gotCount), 66'(expTx.size()));
      for (int i = 0; i < expTx.size() && i < gotCount; i++)
         checkOutput($sformatf("%s tx%0d", tag, i), 66'(gotTx[txBase + i]), 66'(expTx[i]));
      gotCount = gotReq.size() - reqBase;
      checkOutput({tag, " reqCount"}, 66'(gotCount), 66'(expReq.size()));
      for (int i = 0; i < expReq.size() && i < gotCount; i++) begin
         checkOutput($sformatf("%s req%0d", tag, i), gotReq[reqBase + i], expReq[i]);
         checkOutput($sformatf("%s held%0d", tag, i), 66'(gotHeld[reqBase + i]), 66'(1));
      end
      checkOutput({tag, " idle"}, 66'({rxReady, txValid, opValid}), 66'(3'b100));
      @(negedge clock);
   endtask

   task automatic runPacket(input string tag, input logic [7:0] opc, input int len);
      preparePacket(opc, len);
      applyStimulus(tag, 0, pktBytes.size());
      finishPacket(tag);
   endtask

   initial begin
      bit ok;
      int len;
      int pick;
      logic [7:0] opc;

      rstN    = 1'b0;
      rxValid = 1'b0;
      rxData  = 8'h00;
      repeat (3) @(negedge clock);
      #1;
      checkOutput("resetHandshake", 66'({rxReady, txValid, opValid}), 66'(0));
      checkOutput("resetData", 66'({txData, opCode}), 66'(0));
      checkOutput("resetOpA", 66'(opA), 66'(0));
      checkOutput("resetOpB", 66'(opB), 66'(0));
      @(negedge clock);
      rstN = 1'b1;
      #1;
      checkOutput("idleReady", 66'(rxReady), 66'(1));
      @(negedge clock);

      $display("[TB] echo with mid-stream stall");
      payload = {8'h41, 8'h42, 8'h43};
      preparePacket(8'hEC, 7);
      applyStimulus("echoA", 0, 5);
      stallFrom = cycleCount + 1;
      stallTo   = cycleCount + 11;
      applyStimulus("echoB", 5, 6);
      rxData  = 8'h43;
      rxValid = 1'b1;
      @(negedge clock);
      #1;
      checkOutput("echoStall", 66'({txValid, rxReady, txData}), 66'({1'b1, 1'b0, 8'h43}));
      @(negedge clock);
      applyStimulus("echoC", 6, 7);
      finishPacket("echo");

      $display("[TB] add three words");
      payload = {};
      pushWord(32'd1); pushWord(32'd2); pushWord(32'd3);
      runPacket("add123", 8'hA0, 16);

      $display("[TB] slow multiply");
      readyDelay = 5;
      resDelay   = 20;
      payload = {};
      pushWord(32'd7); pushWord(32'd6);
      runPacket("mulSlow", 8'h88, 12);
      readyDelay = 0;
      resDelay   = 0;

      $display("[TB] unknown opcode then add");
      payload = {8'h11, 8'h22, 8'h33, 8'h44};
      runPacket("unknown", 8'h55, 8);
      payload = {};
      pushWord(32'h1234_0000); pushWord(32'h0000_5678);
      runPacket("addAfterDrain", 8'hA0, 12);

      $display("[TB] boundaries");
      payload = {};
      pushWord(32'hCAFE_F00D);
      payload.push_back(8'h99);
      runPacket("addLen9", 8'hA0, 9);
      payload = {};
      runPacket("addLen4", 8'hA0, 4);
      payload = {};
      runPacket("echoLen2", 8'hEC, 2);
      payload = {};
      pushWord(32'd100); pushWord(32'd7); pushWord(32'd0);
      runPacket("divZero", 8'hD0, 16);

      $display("[TB] reset mid-load");
      payload = {};
      pushWord(32'hA5A5_0001); pushWord(32'd2); pushWord(32'd3);
      preparePacket(8'hA0, 16);
      applyStimulus("resetPkt", 0, 10);
      rstN = 1'b0;
      #1;
      checkOutput("midResetHandshake", 66'({rxReady, txValid, opValid, txData}), 66'(0));
      checkOutput("midResetOpA", 66'(opA), 66'(0));
      @(negedge clock);
      rstN = 1'b1;
      @(negedge clock);
      payload = {};
      pushWord(32'd40); pushWord(32'd2);
      runPacket("afterReset", 8'hA0, 12);

`ifdef ALU_CTRL_TIMEOUT_EN
      $display("[TB] truncated header timeout");
      payload = {};
      preparePacket(8'hA0, 12);
      applyStimulus("truncated", 0, 2);
      repeat (TimeoutLimit + 8) @(negedge clock);
      payload = {};
      pushWord(32'd5); pushWord(32'd9);
      runPacket("afterTimeout", 8'hA0, 12);
`endif

      $display("[TB] randomized packets");
      randomTx   = 1;
      randomGaps = 1;
      for (int n = 0; n < 24; n++) begin
         readyDelay = $urandom_range(0, 3);
         resDelay   = $urandom_range(0, 4);
         pick = $urandom_range(0, 4);
         opc  = (pick == 0) ? 8'hEC : (pick == 1) ? 8'hA0 : (pick == 2) ? 8'h88 :
                (pick == 3) ? 8'hD0 : 8'h37;
         len  = $urandom_range(0, 22);
         payload = {};
         for (int k = 4; k < len; k++) payload.push_back(8'($urandom_range(0, 255)));
         runPacket($sformatf("rand%0d", n), opc, len);
      end

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
